// File: rtl/mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between the fetch port and the
// data port. Data has priority; fetch is protected from starvation; hung accesses time out.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_d
);

  localparam int WAIT_W   = $clog2(TIMEOUT + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0]   TIMEOUT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [STARVE_W-1:0] starveCnt;
  logic [WAIT_W-1:0]   waitCnt;
  logic                grantData;
  logic                pickData;

  function automatic logic [STARVE_W-1:0] satInc(input logic [STARVE_W-1:0] v);
    return (v == STARVE_MAX) ? v : v + 1'b1;
  endfunction

  // Fetch wins a tie only once data has beaten a waiting fetch STARVE_LIMIT times in a row.
  assign pickData = d_req && !(if_req && (starveCnt == STARVE_MAX));

  assign stall_if = if_req & ~if_ready;
  assign stall_d  = d_req & ~d_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grantData <= 1'b0;
      starveCnt <= '0;
      waitCnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req || if_req) begin
            state     <= BUSY;
            mem_req   <= 1'b1;
            grantData <= pickData;
            if (pickData) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (if_req) starveCnt <= satInc(starveCnt);
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              starveCnt <= '0;
            end
          end
        end
        BUSY: begin
          // An ack arriving in the timeout cycle still completes the access normally.
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            bus_err <= 1'b0;
            if (grantData) begin
              d_rdata <= mem_rdata;
              d_ready <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
          end else if (waitCnt == TIMEOUT_LAST) begin
            state   <= DONE;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            waitCnt <= waitCnt + 1'b1;
            if (grantData) begin
              d_rdata <= '0;
              d_ready <= 1'b1;
            end else begin
              if_rdata <= '0;
              if_ready <= 1'b1;
            end
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
          bus_err  <= 1'b0;
          waitCnt  <= '0;
          mem_we   <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/store transactions, starvation order, timeout,
// async reset mid-transaction, spurious acks and dropped requests.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_d;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_d(stall_d)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] order;   // 1 = data grant, 0 = fetch grant, index 0 first
    int         cnt;

    reset = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0; mem_ack = 0;
    tick(); tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    reset = 1'b1;
    tick();

    // 1: fetch only, ack in first BUSY cycle
    if_req = 1; if_addr = 32'h100; #1;
    check("t1_stall_if_c0", stall_if, 1);
    check("t1_mem_req_c0", mem_req, 0);
    tick();
    check("t1_mem_req_c1", mem_req, 1);
    check("t1_mem_addr_c1", mem_addr, 32'h100);
    check("t1_mem_we_c1", mem_we, 0);
    check("t1_mem_wdata_c1", mem_wdata, 0);
    check("t1_stall_if_c1", stall_if, 1);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 0;
    check("t1_if_ready_c2", if_ready, 1);
    check("t1_if_rdata_c2", if_rdata, 32'hDEADBEEF);
    check("t1_mem_req_c2", mem_req, 0);
    check("t1_bus_err_c2", bus_err, 0);
    check("t1_stall_if_c2", stall_if, 0);
    if_req = 0;
    tick();
    check("t1_if_ready_c3", if_ready, 0);
    check("t1_if_rdata_hold", if_rdata, 32'hDEADBEEF);

    // 2: store with ack after 3 BUSY cycles
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("t2_mem_req_c%0d", k), mem_req, 1);
      check($sformatf("t2_mem_we_c%0d", k), mem_we, 1);
      check($sformatf("t2_mem_addr_c%0d", k), mem_addr, 32'h40);
      check($sformatf("t2_mem_wdata_c%0d", k), mem_wdata, 32'h12345678);
      check($sformatf("t2_stall_d_c%0d", k), stall_d, 1);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    check("t2_d_ready", d_ready, 1);
    check("t2_bus_err", bus_err, 0);
    check("t2_mem_req_done", mem_req, 0);
    check("t2_stall_d_done", stall_d, 0);
    d_req = 0; d_we = 0;
    tick();
    check("t2_d_ready_off", d_ready, 0);
    check("t2_mem_we_off", mem_we, 0);

    // 3: both requesting continuously -> D,D,D,D,I,D,D,D,D,I
    order = 10'b0111101111;
    if_req = 1; if_addr = 32'h200; d_req = 1; d_addr = 32'h300;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t3_addr_%0d", i), mem_addr, order[i] ? 32'h300 : 32'h200);
      mem_ack = 1; mem_rdata = 32'(i);
      tick();
      mem_ack = 0;
      check($sformatf("t3_d_ready_%0d", i), d_ready, order[i]);
      check($sformatf("t3_if_ready_%0d", i), if_ready, !order[i]);
      tick();
    end
    if_req = 0; d_req = 0;
    check("t3_d_rdata_last", d_rdata, 32'd8);
    check("t3_if_rdata_last", if_rdata, 32'd9);

    // 4a: no ack -> mem_req high 255 cycles, then aborted completion
    d_req = 1; d_we = 0; d_addr = 32'h500;
    tick();
    cnt = 0;
    while (mem_req && cnt < 300) begin
      cnt++;
      tick();
    end
    check("t4_mem_req_cycles", cnt, 255);
    check("t4_d_ready", d_ready, 1);
    check("t4_bus_err", bus_err, 1);
    check("t4_d_rdata", d_rdata, 0);
    d_req = 0;
    tick();
    check("t4_bus_err_off", bus_err, 0);
    check("t4_d_ready_off", d_ready, 0);

    // 4b: ack in the timeout cycle wins
    d_req = 1; d_addr = 32'h600;
    tick();
    for (int k = 0; k < 254; k++) tick();
    check("t4b_mem_req_last", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 0;
    check("t4b_d_ready", d_ready, 1);
    check("t4b_bus_err", bus_err, 0);
    check("t4b_d_rdata", d_rdata, 32'hCAFEF00D);
    d_req = 0;
    tick();

    // 5: async reset mid-BUSY
    d_req = 1; d_we = 1; d_addr = 32'h700; d_wdata = 32'h55;
    tick();
    check("t5_mem_req_busy", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_async_mem_req", mem_req, 0);
    check("t5_async_mem_we", mem_we, 0);
    check("t5_async_mem_addr", mem_addr, 0);
    check("t5_async_mem_wdata", mem_wdata, 0);
    check("t5_async_d_rdata", d_rdata, 0);
    check("t5_async_if_rdata", if_rdata, 0);
    d_req = 0; d_we = 0; if_req = 1; if_addr = 32'h800;
    tick();
    check("t5_d_ready_in_rst", d_ready, 0);
    reset = 1'b1;
    tick();
    check("t5_d_ready_after", d_ready, 0);
    check("t5_fetch_grant_req", mem_req, 1);
    check("t5_fetch_grant_addr", mem_addr, 32'h800);
    mem_ack = 1; mem_rdata = 32'h11;
    tick();
    mem_ack = 0;
    check("t5_if_ready", if_ready, 1);
    check("t5_if_rdata", if_rdata, 32'h11);
    if_req = 0;
    tick();

    // 6: spurious ack in IDLE, dropped d_req mid-BUSY, spurious ack in DONE
    mem_ack = 1; mem_rdata = 32'h99;
    tick();
    mem_ack = 0;
    check("t6_idle_ack_mem_req", mem_req, 0);
    check("t6_idle_ack_if_ready", if_ready, 0);
    check("t6_idle_ack_d_ready", d_ready, 0);
    check("t6_idle_ack_if_rdata", if_rdata, 32'h11);
    d_req = 1; d_addr = 32'h900;
    tick();
    d_req = 0; #1;
    check("t6_stall_d_drop", stall_d, 0);
    check("t6_mem_req_c1", mem_req, 1);
    tick();
    check("t6_mem_req_c2", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h77;
    tick();
    mem_rdata = 32'h66;
    check("t6_d_ready", d_ready, 1);
    check("t6_d_rdata", d_rdata, 32'h77);
    tick();
    mem_ack = 0;
    check("t6_done_ack_d_ready", d_ready, 0);
    check("t6_done_ack_mem_req", mem_req, 0);
    check("t6_done_ack_d_rdata", d_rdata, 32'h77);
    tick();
    check("t6_idle_mem_req", mem_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
